// File: rtl/fme_satd_gen_acc_if.sv
// Row-in / SATD-out bundle between the FME interpolator, the SATD engine and the cost comparator.
interface fme_satd_gen_acc_if #(
    parameter int BIT_DEPTH    = 8,
    parameter int BLK_LOG2_MAX = 4
);
    logic                              clear_i;
    logic                              valid_i;
    logic [2:0]                        blk_log2_i;
    logic [BIT_DEPTH-1:0]              cur_p0_i, cur_p1_i, cur_p2_i, cur_p3_i;
    logic [BIT_DEPTH-1:0]              ref_p0_i, ref_p1_i, ref_p2_i, ref_p3_i;
    logic [BIT_DEPTH+6:0]              satd_4x4_o;
    logic                              satd_4x4_valid_o;
    logic [BIT_DEPTH+6+BLK_LOG2_MAX:0] satd_blk_o;
    logic                              satd_blk_valid_o;
    logic [BLK_LOG2_MAX-1:0]           blk_idx_o;

    modport master (
        output clear_i, valid_i, blk_log2_i,
        output cur_p0_i, cur_p1_i, cur_p2_i, cur_p3_i,
        output ref_p0_i, ref_p1_i, ref_p2_i, ref_p3_i,
        input  satd_4x4_o, satd_4x4_valid_o, satd_blk_o, satd_blk_valid_o, blk_idx_o
    );

    modport slave (
        input  clear_i, valid_i, blk_log2_i,
        input  cur_p0_i, cur_p1_i, cur_p2_i, cur_p3_i,
        input  ref_p0_i, ref_p1_i, ref_p2_i, ref_p3_i,
        output satd_4x4_o, satd_4x4_valid_o, satd_blk_o, satd_blk_valid_o, blk_idx_o
    );
endinterface

// File: rtl/fme_satd_gen_acc.sv
// Streaming 4x4 Hadamard SATD: row transform into a ping-pong transpose buffer, column
// transform + abs + accumulate, rounding, then optional accumulation over a group of blocks.
module fme_satd_gen_acc #(
    parameter int BIT_DEPTH    = 8,
    parameter int BLK_LOG2_MAX = 4,
    parameter int ROUND_EN     = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    fme_satd_gen_acc_if.slave bus
);
    localparam int DW = BIT_DEPTH + 1;
    localparam int RW = BIT_DEPTH + 3;
    localparam int CW = BIT_DEPTH + 5;
    localparam int AW = BIT_DEPTH + 4;
    localparam int SW = BIT_DEPTH + 8;
    localparam int OW = BIT_DEPTH + 7;
    localparam int GW = OW + BLK_LOG2_MAX;
    localparam int IW = BLK_LOG2_MAX;

    logic [BIT_DEPTH-1:0] cur_pel [4];
    logic [BIT_DEPTH-1:0] ref_pel [4];
    assign cur_pel[0] = bus.cur_p0_i;
    assign cur_pel[1] = bus.cur_p1_i;
    assign cur_pel[2] = bus.cur_p2_i;
    assign cur_pel[3] = bus.cur_p3_i;
    assign ref_pel[0] = bus.ref_p0_i;
    assign ref_pel[1] = bus.ref_p1_i;
    assign ref_pel[2] = bus.ref_p2_i;
    assign ref_pel[3] = bus.ref_p3_i;

    logic accept;
    assign accept = bus.valid_i && !bus.clear_i;

    logic signed [RW-1:0] diff_ext [4];
    logic signed [RW-1:0] row_h [4];
    logic signed [RW-1:0] rs0, rs1, rt0, rt1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_diff
            logic signed [DW-1:0] diff;
            assign diff         = $signed({1'b0, cur_pel[gi]}) - $signed({1'b0, ref_pel[gi]});
            assign diff_ext[gi] = $signed({{(RW-DW){diff[DW-1]}}, diff});
        end
    endgenerate

    assign rs0      = diff_ext[0] + diff_ext[1];
    assign rs1      = diff_ext[2] + diff_ext[3];
    assign rt0      = diff_ext[0] - diff_ext[1];
    assign rt1      = diff_ext[2] - diff_ext[3];
    assign row_h[0] = rs0 + rs1;
    assign row_h[1] = rs0 - rs1;
    assign row_h[2] = rt0 - rt1;
    assign row_h[3] = rt0 + rt1;

    logic [1:0]    row_q, row_d;
    logic          wr_bank_q, wr_bank_d;
    logic [IW-1:0] in_cnt_q, in_cnt_d;
    logic [2:0]    in_log2_q, in_log2_d;
    logic          col_act_q, col_act_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] col_tag_idx_q, col_tag_idx_d;
    logic          col_tag_last_q, col_tag_last_d;

    logic [2:0]    log2_clamped;
    logic [IW:0]   grp_len;
    logic          in_last;

    assign log2_clamped = (bus.blk_log2_i > 3'(BLK_LOG2_MAX)) ? 3'(BLK_LOG2_MAX) : bus.blk_log2_i;
    assign grp_len      = (IW+1)'(1) << in_log2_q;
    assign in_last      = ({1'b0, in_cnt_q} == (grp_len - (IW+1)'(1)));

    // Group size and block index are tagged at row 3 and ride down the pipeline with the block.
    always_comb begin
        row_d          = row_q;
        wr_bank_d      = wr_bank_q;
        in_cnt_d       = in_cnt_q;
        in_log2_d      = in_log2_q;
        col_act_d      = col_act_q && (col_idx_q != 2'd3);
        col_idx_d      = col_act_q ? col_idx_q + 2'd1 : col_idx_q;
        rd_bank_d      = rd_bank_q;
        col_tag_idx_d  = col_tag_idx_q;
        col_tag_last_d = col_tag_last_q;
        if (accept) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd0 && in_cnt_q == '0) begin
                in_log2_d = log2_clamped;
            end
            if (row_q == 2'd3) begin
                wr_bank_d      = ~wr_bank_q;
                in_cnt_d       = in_last ? '0 : in_cnt_q + IW'(1);
                col_act_d      = 1'b1;
                col_idx_d      = 2'd0;
                rd_bank_d      = wr_bank_q;
                col_tag_idx_d  = in_cnt_q;
                col_tag_last_d = in_last;
            end
        end
        if (bus.clear_i) begin
            row_d          = '0;
            wr_bank_d      = 1'b0;
            in_cnt_d       = '0;
            in_log2_d      = '0;
            col_act_d      = 1'b0;
            col_idx_d      = '0;
            rd_bank_d      = 1'b0;
            col_tag_idx_d  = '0;
            col_tag_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_q          <= '0;
            wr_bank_q      <= 1'b0;
            in_cnt_q       <= '0;
            in_log2_q      <= '0;
            col_act_q      <= 1'b0;
            col_idx_q      <= '0;
            rd_bank_q      <= 1'b0;
            col_tag_idx_q  <= '0;
            col_tag_last_q <= 1'b0;
        end else begin
            row_q          <= row_d;
            wr_bank_q      <= wr_bank_d;
            in_cnt_q       <= in_cnt_d;
            in_log2_q      <= in_log2_d;
            col_act_q      <= col_act_d;
            col_idx_q      <= col_idx_d;
            rd_bank_q      <= rd_bank_d;
            col_tag_idx_q  <= col_tag_idx_d;
            col_tag_last_q <= col_tag_last_d;
        end
    end

    logic signed [RW-1:0] tbuf_q [2][4][4];

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int c = 0; c < 4; c++) begin
                tbuf_q[wr_bank_q][row_q][c] <= row_h[c];
            end
        end
    end

    logic signed [CW-1:0] col_ext [4];
    logic signed [CW-1:0] col_h [4];
    logic signed [CW-1:0] cs0, cs1, ct0, ct1;
    logic [AW-1:0]        col_abs [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic signed [RW-1:0] col_v;
            assign col_v        = tbuf_q[rd_bank_q][gi][col_idx_q];
            assign col_ext[gi]  = $signed({{(CW-RW){col_v[RW-1]}}, col_v});
            assign col_abs[gi]  = col_h[gi][CW-1] ? AW'(-col_h[gi]) : AW'(col_h[gi]);
        end
    endgenerate

    assign cs0      = col_ext[0] + col_ext[1];
    assign cs1      = col_ext[2] + col_ext[3];
    assign ct0      = col_ext[0] - col_ext[1];
    assign ct1      = col_ext[2] - col_ext[3];
    assign col_h[0] = cs0 + cs1;
    assign col_h[1] = cs0 - cs1;
    assign col_h[2] = ct0 - ct1;
    assign col_h[3] = ct0 + ct1;

    logic [AW-1:0]   abs_q [4];
    logic            s1_v_q, s1_first_q, s1_last_q, s1_glast_q;
    logic [IW-1:0]   s1_idx_q;
    logic [SW-1:0]   acc_q;
    logic            acc_done_q, acc_glast_q;
    logic [IW-1:0]   acc_idx_q;
    logic [OW-1:0]   rnd_q;
    logic            rnd_v_q, rnd_glast_q;
    logic [IW-1:0]   rnd_idx_q;
    logic [OW-1:0]   satd_q;
    logic            satd_v_q, blk_v_q;
    logic [IW-1:0]   idx_q;
    logic [GW-1:0]   blk_q, grp_acc_q;

    logic [SW-1:0]   col_sum;
    logic [OW-1:0]   rnd_val;
    logic [GW-1:0]   grp_sum;

    assign col_sum = SW'(abs_q[0]) + SW'(abs_q[1]) + SW'(abs_q[2]) + SW'(abs_q[3]);
    assign rnd_val = OW'((acc_q + SW'(ROUND_EN != 0)) >> 1);
    assign grp_sum = ((rnd_idx_q == '0) ? '0 : grp_acc_q) + GW'(rnd_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < 4; c++) abs_q[c] <= '0;
            {s1_v_q, s1_first_q, s1_last_q, s1_glast_q, s1_idx_q} <= '0;
            {acc_q, acc_done_q, acc_glast_q, acc_idx_q}           <= '0;
            {rnd_q, rnd_v_q, rnd_glast_q, rnd_idx_q}              <= '0;
            {satd_q, satd_v_q, blk_v_q, idx_q, blk_q, grp_acc_q}  <= '0;
        end else if (bus.clear_i) begin
            {s1_v_q, acc_done_q, rnd_v_q}                         <= '0;
            {satd_q, satd_v_q, blk_v_q, idx_q, blk_q, grp_acc_q}  <= '0;
        end else begin
            s1_v_q     <= col_act_q;
            s1_first_q <= (col_idx_q == 2'd0);
            s1_last_q  <= (col_idx_q == 2'd3);
            s1_idx_q   <= col_tag_idx_q;
            s1_glast_q <= col_tag_last_q;
            if (col_act_q) begin
                for (int c = 0; c < 4; c++) abs_q[c] <= col_abs[c];
            end
            acc_done_q <= s1_v_q && s1_last_q;
            if (s1_v_q) begin
                acc_q       <= (s1_first_q ? '0 : acc_q) + col_sum;
                acc_idx_q   <= s1_idx_q;
                acc_glast_q <= s1_glast_q;
            end
            rnd_v_q <= acc_done_q;
            if (acc_done_q) begin
                rnd_q       <= rnd_val;
                rnd_idx_q   <= acc_idx_q;
                rnd_glast_q <= acc_glast_q;
            end
            satd_v_q <= rnd_v_q;
            blk_v_q  <= rnd_v_q && rnd_glast_q;
            if (rnd_v_q) begin
                satd_q    <= rnd_q;
                idx_q     <= rnd_idx_q;
                grp_acc_q <= grp_sum;
                if (rnd_glast_q) blk_q <= grp_sum;
            end
        end
    end

    assign bus.satd_4x4_o       = satd_q;
    assign bus.satd_4x4_valid_o = satd_v_q;
    assign bus.satd_blk_o       = blk_q;
    assign bus.satd_blk_valid_o = blk_v_q;
    assign bus.blk_idx_o        = idx_q;
endmodule

// File: tb/tb_fme_satd_gen_acc.sv
// Scoreboard bench for fme_satd_gen_acc: a 2-D Hadamard matrix model predicts every result.
`timescale 1ns/1ps
module tb_fme_satd_gen_acc;
    localparam int BD  = 8;
    localparam int BLM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fme_satd_gen_acc_if #(.BIT_DEPTH(BD), .BLK_LOG2_MAX(BLM)) bus ();

    fme_satd_gen_acc #(.BIT_DEPTH(BD), .BLK_LOG2_MAX(BLM), .ROUND_EN(1)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int satd;
        int idx;
        bit last;
        int blk;
        int due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   mdiff[4][4];
    int   mrow = 0, gpos = 0, glog2 = 0, gsum = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endfunction

    // Natural-order Walsh-Hadamard entry: sign of (-1)^popcount(u & i).
    function automatic int hsgn(int u, int i);
        return ($countones(u & i) % 2 == 1) ? -1 : 1;
    endfunction

    function automatic int ref_satd();
        int s;
        int y;
        s = 0;
        for (int u = 0; u < 4; u++) begin
            for (int v = 0; v < 4; v++) begin
                y = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        y += hsgn(u, i) * hsgn(v, j) * mdiff[i][j];
                s += (y < 0) ? -y : y;
            end
        end
        return (s + 1) / 2;
    endfunction

    function automatic void model_row(input logic [31:0] cp, input logic [31:0] rp, input int lg);
        exp_t e;
        if (mrow == 0 && gpos == 0) glog2 = (lg > BLM) ? BLM : lg;
        for (int c = 0; c < 4; c++) mdiff[mrow][c] = int'(cp[8*c +: 8]) - int'(rp[8*c +: 8]);
        if (mrow == 3) begin
            e.satd = ref_satd();
            e.idx  = gpos;
            e.last = (gpos == (1 << glog2) - 1);
            gsum   = ((gpos == 0) ? 0 : gsum) + e.satd;
            e.blk  = gsum;
            e.due  = cyc + 7;
            exp_q.push_back(e);
            gpos = e.last ? 0 : gpos + 1;
        end
        mrow = (mrow + 1) % 4;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mrow = 0;
        gpos = 0;
        gsum = 0;
    endfunction

    function automatic logic [31:0] rep(input logic [7:0] v);
        return {4{v}};
    endfunction

    task automatic drive_pels(input logic [31:0] cp, input logic [31:0] rp);
        {bus.cur_p3_i, bus.cur_p2_i, bus.cur_p1_i, bus.cur_p0_i} = cp;
        {bus.ref_p3_i, bus.ref_p2_i, bus.ref_p1_i, bus.ref_p0_i} = rp;
    endtask

    task automatic send_row(input logic [31:0] cp, input logic [31:0] rp, input int lg);
        bus.valid_i    = 1'b1;
        bus.blk_log2_i = 3'(lg);
        drive_pels(cp, rp);
        @(posedge clk);
        #1;
        model_row(cp, rp, lg);
    endtask

    task automatic send_block(input logic [31:0] cp, input logic [31:0] rp, input int lg);
        for (int r = 0; r < 4; r++) send_row(cp, rp, lg);
    endtask

    task automatic send_rand_block(input int lg);
        for (int r = 0; r < 4; r++) send_row($urandom, $urandom, lg);
    endtask

    task automatic idle(input int n);
        bus.valid_i    = 1'b0;
        bus.blk_log2_i = 3'($urandom_range(0, 7));
        drive_pels($urandom, $urandom);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_satd_4x4"},  int'(bus.satd_4x4_o), 0);
        chk({tag, "_4x4_valid"}, int'(bus.satd_4x4_valid_o), 0);
        chk({tag, "_satd_blk"},  int'(bus.satd_blk_o), 0);
        chk({tag, "_blk_valid"}, int'(bus.satd_blk_valid_o), 0);
        chk({tag, "_blk_idx"},   int'(bus.blk_idx_o), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.satd_4x4_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_4x4_valid", int'(bus.satd_4x4_valid_o), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("satd_4x4", int'(bus.satd_4x4_o), mon_e.satd);
                    chk("blk_idx", int'(bus.blk_idx_o), mon_e.idx);
                    chk("blk_valid", int'(bus.satd_blk_valid_o), int'(mon_e.last));
                    if (mon_e.last) chk("satd_blk", int'(bus.satd_blk_o), mon_e.blk);
                    chk("latency_edge", cyc, mon_e.due);
                    $display("result edge=%0d satd_4x4=%0d idx=%0d blk_valid=%0b satd_blk=%0d",
                             cyc, bus.satd_4x4_o, bus.blk_idx_o, bus.satd_blk_valid_o, bus.satd_blk_o);
                end
            end else if (bus.satd_blk_valid_o) begin
                chk("orphan_blk_valid", int'(bus.satd_blk_valid_o), 0);
            end
        end
    end

    int lgs[5] = '{0, 1, 2, 4, 7};
    int lg_sel;
    int lg_k = 0;

    initial begin
        bus.clear_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.blk_log2_i = 3'd0;
        drive_pels('0, '0);
        rst_n = 1'b0;
        #2;
        check_zero("reset");
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed single blocks, one-block groups.
        send_block(rep(8'h80), rep(8'h80), 0);
        send_block(rep(8'hFF), rep(8'h00), 0);
        for (int r = 0; r < 4; r++)
            send_row((r % 2 == 1) ? 32'hFF00FF00 : 32'h00FF00FF,
                     (r % 2 == 1) ? 32'h00FF00FF : 32'hFF00FF00, 0);
        send_row({24'h404040, 8'h4A}, rep(8'h40), 0);
        for (int r = 0; r < 3; r++) send_row(rep(8'h40), rep(8'h40), 0);
        idle(1);
        drain();

        // Four back-to-back full-scale blocks in a 4-block group.
        for (int b = 0; b < 4; b++) send_block(rep(8'hFF), rep(8'h00), 2);
        idle(1);
        drain();

        // Random pels, random gaps, group size cycling 0/1/2/4/7(clamped).
        for (int b = 0; b < 64; b++) begin
            if (gpos == 0) begin
                lg_sel = lgs[lg_k % 5];
                lg_k++;
            end else begin
                lg_sel = int'($urandom_range(0, 7));
            end
            for (int r = 0; r < 4; r++) begin
                send_row($urandom, $urandom, (r == 0) ? lg_sel : int'($urandom_range(0, 7)));
                if (b % 8 == 3 && r == 1) idle(10);
                else if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        idle(1);
        drain();

        // Flush to realign groups; outputs must return to zero.
        bus.clear_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        model_reset();
        check_zero("after_clear");

        // Clear after row 2 of block 1 of a 4-block group, with valid_i high on the clear edge.
        send_rand_block(2);
        for (int r = 0; r < 3; r++) send_row($urandom, $urandom, 2);
        bus.clear_i = 1'b1;
        bus.valid_i = 1'b1;
        drive_pels($urandom, $urandom);
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        model_reset();
        idle(12);
        send_rand_block(0);
        idle(1);
        drain();

        // Async reset in the middle of a column phase.
        send_rand_block(0);
        bus.valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(12);

        // Fresh stream after reset.
        send_rand_block(1);
        send_rand_block(1);
        idle(1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fme_satd_gen_acc.md
Name: fme_satd_gen_acc

Overview:
- Streaming 4x4 Hadamard SATD engine for fractional motion estimation.
- Takes one 4-pel row of current-MB and sub-pel prediction samples per accepted cycle.
- Emits the rounded SATD of every 4x4 block, plus a runtime-selectable accumulated SATD over 1/2/4/…/2^BLK_LOG2_MAX consecutive 4x4 blocks (e.g. 8x8 or 16x16 partitions).
- Fully pipelined with a ping-pong transpose buffer, so rows can arrive every cycle without bubbles. Sits between the FME interpolator and the cost comparator.

Parameters:
- BIT_DEPTH, 8, pel sample width.
- BLK_LOG2_MAX, 4, max log2 of 4x4 blocks per accumulation group (4 → 16 blocks, i.e. 16x16).
- ROUND_EN, 1, 1: 4x4 SATD = (sum+1)>>1; 0: sum>>1.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush; drops all partial and in-flight work.
- valid_i  in  1  row valid; row accepted on each rising edge where high.
- blk_log2_i  in  3  group size log2; sampled on the first row of each group; values above BLK_LOG2_MAX are clamped.
- cur_p0_i..cur_p3_i  in  BIT_DEPTH each  current-block row pels, column 0..3.
- ref_p0_i..ref_p3_i  in  BIT_DEPTH each  prediction row pels.
- satd_4x4_o  out  BIT_DEPTH+7  rounded 4x4 SATD.
- satd_4x4_valid_o  out  1  one-cycle pulse per completed 4x4.
- satd_blk_o  out  BIT_DEPTH+7+BLK_LOG2_MAX  group accumulated SATD (sum of satd_4x4_o values).
- satd_blk_valid_o  out  1  one-cycle pulse on last 4x4 of a group.
- blk_idx_o  out  BLK_LOG2_MAX  index of the 4x4 within its group, valid with satd_4x4_valid_o.

Behaviour:
- Reset (async) and clear_i (sync, next edge) drive the following to 0: all outputs, row counter, block counter, pipeline valids, transpose-buffer select. clear_i has priority over valid_i in the same cycle.
- Differences: diff = {0,cur} − {0,ref}, signed, BIT_DEPTH+1 bits.
- Row 1-D Hadamard (combinational, +2 bits) is written into the transpose buffer at row index 0..3 on each accepted row.
- Two 4x4 banks (ping-pong). Write bank toggles after row 3. Read of a bank never collides with a write to the same bank.
- Once row 3 of a block is accepted, the column phase reads 4 columns on the 4 following cycles, unconditionally and independent of valid_i.
- Column 1-D Hadamard is +2 bits (BIT_DEPTH+5 signed). Take abs, register it, then accumulate the 4 per-column sums.
- Latency: satd_4x4_valid_o pulses exactly 7 cycles after the edge accepting row 3.
- Continuous valid_i yields one pulse every 4 cycles.
- Gaps in valid_i: the partial block is held indefinitely and the latency is unchanged.
- ROUND_EN rounding is applied to a (BIT_DEPTH+8)-bit sum, then truncated to BIT_DEPTH+7 bits. No overflow is possible.
- Group accumulation:
  - A group counter counts emitted 4x4 results.
  - satd_blk_o = sum of the group's satd_4x4_o values.
  - satd_blk_valid_o and satd_blk_o update in the same cycle as the last 4x4's satd_4x4_valid_o.
  - The accumulator restarts (does not add to the previous group) on index 0.
  - blk_log2_i = 0 gives satd_blk_valid_o = satd_4x4_valid_o on every block.
  - blk_log2_i is latched when row 0 of block 0 of a group is accepted; changes mid-group are ignored.
  - The latched size travels with the pipeline, so back-to-back groups of different sizes are correct.
- Outputs hold their value between pulses. Valids are single-cycle.
- Reset asserted mid-block: all state is lost and no spurious valid occurs after deassertion.

Test Plan:
- BIT_DEPTH=8, ROUND_EN=1, blk_log2_i=0; 4 rows with cur=ref=0x80 → satd_4x4_o=0, both valids pulse 7 cycles after row 3.
- cur=255, ref=0 all pels → satd_4x4_o=2040 (DC 4080). Checkerboard ±255 diff pattern → 2040. Only cur(0,0)=10, rest equal → 80. With ROUND_EN=0, the single-pel case → 80 and a sum of 3 → 1.
- blk_log2_i=2, 16 rows back-to-back all diff=255 → four satd_4x4_valid_o pulses 4 cycles apart with blk_idx_o 0..3, and satd_blk_o=8160 with satd_blk_valid_o on the 4th pulse only.
- Random valid_i gaps (including 10-cycle stalls mid-block), random pels over 64 blocks, blk_log2_i cycling 0/1/2/4 → every result matches the reference model. blk_log2_i=7 is clamped to 4.
- clear_i asserted after row 2 of block 1 in a 4-block group → no further valids. The next 4 rows give a correct standalone result with blk_idx_o=0.
- rst_n_i pulsed mid column phase → all outputs 0 immediately, no valid pulse after release. Then a new stream behaves as from power-on.
